// File: rtl/shared_bram_if.sv
// Port-B bus between the shared-BRAM agent (master) and the dual-port BRAM (slave).
interface shared_bram_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [DATA_W-1:0] bram_dout;

  modport master (output bram_addr, output bram_din, output bram_we, input bram_dout);
  modport slave  (input bram_addr, input bram_din, input bram_we, output bram_dout);
endinterface

// File: rtl/shared_bram_agent.sv
// PL-side agent for a PS/PL shared BRAM: fill pass, status polling, doorbell ack and irq.
// Optional periodic interrupt enabled by defining SHARED_BRAM_PERIODIC_IRQ_EN.
module shared_bram_agent #(
  parameter int          ADDR_W      = 11,
  parameter int          DATA_W      = 32,
  parameter int unsigned STATUS_ADDR = 0,
  parameter int unsigned TICK_MAX    = 28'h8F0_D17F
) (
  input  logic              clk,
  input  logic              rst,
  shared_bram_if.master     bram,
  input  logic              ps_doorbell,
  output logic              irq,
  output logic [1:0]        irq_src,
  output logic              irq_toggle,
  output logic [DATA_W-1:0] status_word,
  output logic              init_done
);

  localparam int FW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ST_ADDR  = ADDR_W'(STATUS_ADDR);
  localparam logic [ADDR_W-1:0] ACK_ADDR = ADDR_W'(STATUS_ADDR + 1);

  typedef enum logic [2:0] {FILL, POLL_RD, POLL_WAIT, POLL_CAP, ACK_WR} state_e;

  state_e            state_q;
  logic [FW-1:0]     fill_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              we_q;
  logic [DATA_W-1:0] status_q;
  logic              init_q;
  logic              irq_q;
  logic [1:0]        irq_src_q;

  logic [2:0]        db_q;
  logic              db_rise;
  logic              pend_q;
  logic              pend_d;
  logic              ack_ev;
  logic              tick;

  // Doorbell crosses clock domains: two sync flops plus one history flop for edge detect.
  assign db_rise = db_q[1] & ~db_q[2];
  assign ack_ev  = (state_q == ACK_WR);
  assign pend_d  = db_rise | (pend_q & ~ack_ev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      db_q   <= {db_q[1:0], ps_doorbell};
      pend_q <= pend_d;
    end
  end

`ifdef SHARED_BRAM_PERIODIC_IRQ_EN
  localparam int CNT_W = (TICK_MAX == 0) ? 1 : $clog2(64'(TICK_MAX) + 64'd1);

  logic [CNT_W-1:0] cnt_q;
  logic             toggle_q;

  assign tick       = (cnt_q == CNT_W'(TICK_MAX));
  assign irq_toggle = toggle_q;

  // Free-running from reset, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      toggle_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) toggle_q <= ~toggle_q;
    end
  end
`else
  assign tick       = 1'b0;
  assign irq_toggle = 1'b0;
`endif

  // Outputs are registered: the state value always matches what is on the bus this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      fill_q    <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      status_q  <= '0;
      init_q    <= 1'b0;
      irq_q     <= 1'b0;
      irq_src_q <= 2'b00;
    end else begin
      irq_q     <= ack_ev | tick;
      irq_src_q <= {ack_ev, tick};
      case (state_q)
        FILL: begin
          if (fill_q[ADDR_W]) begin
            state_q <= POLL_RD;
            addr_q  <= ST_ADDR;
            we_q    <= 1'b0;
            init_q  <= 1'b1;
          end else begin
            addr_q <= fill_q[ADDR_W-1:0];
            din_q  <= DATA_W'(fill_q[ADDR_W-1:0]);
            we_q   <= 1'b1;
            fill_q <= fill_q + FW'(1);
          end
        end
        POLL_RD: begin
          state_q <= POLL_WAIT;
          addr_q  <= ST_ADDR;
          we_q    <= 1'b0;
        end
        POLL_WAIT: begin
          state_q <= POLL_CAP;
        end
        POLL_CAP: begin
          status_q <= bram.bram_dout;
          if (pend_q) begin
            state_q <= ACK_WR;
            addr_q  <= ACK_ADDR;
            din_q   <= bram.bram_dout + DATA_W'(1);
            we_q    <= 1'b1;
          end else begin
            state_q <= POLL_RD;
          end
        end
        ACK_WR: begin
          state_q <= POLL_RD;
          addr_q  <= ST_ADDR;
          we_q    <= 1'b0;
        end
        default: begin
          state_q <= FILL;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bram.bram_addr = addr_q;
  assign bram.bram_din  = din_q;
  assign bram.bram_we   = we_q;
  assign irq            = irq_q;
  assign irq_src        = irq_src_q;
  assign status_word    = status_q;
  assign init_done      = init_q;

endmodule

// File: tb/tb_shared_bram_agent.sv
// Scoreboard bench for shared_bram_agent: expected BRAM writes and irq pattern come from a
// behavioural model; a negedge monitor compares them against the DUT.
module tb_shared_bram_agent;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int PERIOD = 16;  // TICK_MAX + 1
`ifdef SHARED_BRAM_PERIODIC_IRQ_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                ack;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ps_doorbell = 1'b0;
  logic              irq;
  logic [1:0]        irq_src;
  logic              irq_toggle;
  logic [DATA_W-1:0] status_word;
  logic              init_done;

  shared_bram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  shared_bram_agent #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STATUS_ADDR(0), .TICK_MAX(15)
  ) dut (
    .clk(clk), .rst(rst), .bram(bif), .ps_doorbell(ps_doorbell),
    .irq(irq), .irq_src(irq_src), .irq_toggle(irq_toggle),
    .status_word(status_word), .init_done(init_done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always @(posedge clk) begin
    if (bif.bram_we) mem[bif.bram_addr] <= bif.bram_din;
    bif.bram_dout <= mem[bif.bram_addr];
  end

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  ack_due = 1'b0;
  bit  tog_exp = 1'b0;
  int  coinc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: cyc counts clock edges since reset release.
  always @(negedge clk) begin
    bit  per;
    wr_t e;
    if (rst) begin
      cyc     = 0;
      ack_due = 1'b0;
      tog_exp = 1'b0;
    end else begin
      cyc++;
      per = PER_EN && (cyc % PERIOD == 0);
      if (per) tog_exp = ~tog_exp;
      if (per && ack_due) coinc++;
      chk("irq", irq, per | ack_due);
      chk("irq_src", irq_src, {ack_due, per});
      chk("irq_toggle", irq_toggle, tog_exp);
      chk("init_done", init_done, cyc >= 17);
      ack_due = 1'b0;
      if (bif.bram_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write (cycle %0d)",
                   bif.bram_addr, bif.bram_din, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", bif.bram_addr, e.addr);
          chk("write_data", bif.bram_din, e.data);
          ack_due = e.ack;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_fill();
    wr_t e;
    for (int a = 0; a < 2**ADDR_W; a++) begin
      e.addr = ADDR_W'(a);
      e.data = DATA_W'(a);
      e.ack  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_ack(input logic [DATA_W-1:0] status);
    wr_t e;
    e.addr = ADDR_W'(1);
    e.data = status + DATA_W'(1);
    e.ack  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_we", bif.bram_we, 1'b0);
    chk("rst_addr", bif.bram_addr, '0);
    chk("rst_din", bif.bram_din, '0);
    chk("rst_irq", {irq, irq_src}, 3'b000);
    chk("rst_toggle", irq_toggle, 1'b0);
    chk("rst_status", status_word, '0);
    chk("rst_init_done", init_done, 1'b0);
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes outstanding after %0d cycles, expected 0", exp_q.size(), maxc);
      exp_q.delete();
    end
    step();
    step();
  endtask

  task automatic doorbell_ack(input logic [DATA_W-1:0] val);
    mem[0] = val;
    repeat ($urandom_range(1, 4)) step();
    ps_doorbell = 1'b1;
    push_ack(val);
    repeat (3) step();
    ps_doorbell = 1'b0;
    wait_drain(40);
    chk("status_after_ack", status_word, val);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    int n;

    // Reset, then abort a fill part-way and restart it.
    repeat (2) step();
    chk_reset_outputs();
    exp_q.delete();
    push_fill();
    rst = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    exp_q.delete();
    step();
    chk_reset_outputs();

    push_fill();
    rst = 1'b0;
    while (cyc < 5) step();
    ps_doorbell = 1'b1;  // edge lands during fill; ack of fill value 0 follows
    push_ack(32'd0);
    repeat (3) step();
    ps_doorbell = 1'b0;
    while (cyc < 18) step();
    chk("mem7_after_fill", mem[7], 32'd7);
    wait_drain(40);

    // Status capture without a doorbell: no write may appear.
    mem[0] = 32'hA5;
    n = 0;
    while (status_word !== 32'hA5 && n < 8) begin
      step();
      n++;
    end
    chk("status_capture", status_word, 32'hA5);
    repeat (10) step();

    doorbell_ack(32'hA5);
    doorbell_ack(32'hFFFF_FFFF);

    for (int i = 0; i < 20; i++) begin
      v = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        mem[0] = v;
        repeat (10) step();
        chk("status_idle", status_word, v);
      end else begin
        doorbell_ack(v);
      end
    end

    // Sweep doorbell phase against the periodic counter to force coincident events.
    for (int j = 0; j < 48; j++) begin
      while (cyc % PERIOD != j % PERIOD) step();
      repeat (j / PERIOD) step();
      doorbell_ack($urandom);
    end
    if (PER_EN) chk("coincident_irq_seen", coinc > 0, 1'b1);
    repeat (40) step();

    // Abort in the middle of an ack write.
    mem[0] = 32'h1234;
    ps_doorbell = 1'b1;
    push_ack(32'h1234);
    n = 0;
    while (!(bif.bram_we && bif.bram_addr == ADDR_W'(1)) && n < 40) begin
      step();
      n++;
    end
    chk("ack_write_seen", bif.bram_we, 1'b1);
    ps_doorbell = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    step();
    chk_reset_outputs();
    push_fill();
    rst = 1'b0;
    wait_drain(40);
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
